// File: rtl/pipeline_pkg.sv
// Shared decode-stage definitions: opcodes, ALU function codes and the
// interrupt control unit state encoding.
package pipeline_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_PUSH = 5'b01100;
    localparam logic [4:0] OP_POP  = 5'b01101;
    localparam logic [4:0] OP_RTI  = 5'b11011;

    localparam logic [3:0] NOP_ALU  = 4'b0000;
    localparam logic [3:0] PUSH_ALU = 4'b0100;

    typedef enum logic [2:0] {
        ICU_IDLE,
        ICU_DRAIN,
        ICU_PUSH_HI,
        ICU_PUSH_LO,
        ICU_VEC_HI,
        ICU_VEC_LO,
        ICU_LOAD
    } icu_state_t;

endpackage

// File: rtl/int_edge_latch.sv
// Rising-edge detector on the external INT pin feeding a one-deep pending
// latch; edges arriving while already pending are dropped.
module int_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic int_req,
    input  logic clear,
    output logic pending
);

    logic int_prev;

    // Clear wins over a coincident edge: acceptance consumes the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_prev <= 1'b0;
            pending  <= 1'b0;
        end else begin
            int_prev <= int_req;
            if (clear) begin
                pending <= 1'b0;
            end else if (int_req && !int_prev) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_control_unit.sv
// Hardware interrupt entry sequencer: drains the pipeline, pushes the return PC,
// fetches the ISR vector and loads it, owning the shared CU nets meanwhile.
module interrupt_control_unit
    import pipeline_pkg::*;
#(
    parameter int PC_WIDTH     = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int FLAG_WIDTH   = 3,
    parameter int DRAIN_CYCLES = 3,
    parameter logic [PC_WIDTH-1:0] VECTOR_ADDR = 'h2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  int_req,
    input  logic                  stall,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [FLAG_WIDTH-1:0] flags,
    input  logic                  rti,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  int_flag,
    output logic                  fetch_hold,
    output logic                  branch,
    output logic                  data_read,
    output logic                  data_write,
    output logic                  DMR,
    output logic                  DMW,
    output logic                  stack_operation,
    output logic                  push_pop,
    output logic                  write_sp,
    output logic [3:0]            alu_function,
    output logic [DATA_WIDTH-1:0] stack_wdata,
    output logic [PC_WIDTH-1:0]   mem_addr,
    output logic                  pc_write,
    output logic [PC_WIDTH-1:0]   pc_next,
    output logic [FLAG_WIDTH-1:0] saved_flags,
    output logic                  flags_restore
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    icu_state_t            state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [PC_WIDTH-1:0]   pc_saved;
    logic [DATA_WIDTH-1:0] vec_hi;
    logic                  pending, accept, restore_q;

    logic       branch_d, data_read_d, data_write_d, dmr_d, dmw_d;
    logic       stack_op_d, push_pop_d, write_sp_d;
    logic [3:0] alu_d;

    int_edge_latch u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .int_req (int_req),
        .clear   (accept),
        .pending (pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ICU_IDLE;
            cnt         <= '0;
            pc_saved    <= '0;
            vec_hi      <= '0;
            saved_flags <= '0;
            restore_q   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            restore_q <= (state == ICU_IDLE) && rti;
            if (accept) begin
                pc_saved    <= pc;
                saved_flags <= flags;
            end
            // The high vector word returns during VEC_LO (1-cycle read latency).
            if (state == ICU_VEC_LO && !stall) begin
                vec_hi <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            ICU_IDLE: begin
                if (pending && !stall) begin
                    accept     = 1'b1;
                    state_next = ICU_DRAIN;
                    cnt_next   = '0;
                end
            end
            ICU_DRAIN: begin
                if (!stall) begin
                    if (cnt == CNT_LAST) begin
                        state_next = ICU_PUSH_HI;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            ICU_PUSH_HI: if (!stall) state_next = ICU_PUSH_LO;
            ICU_PUSH_LO: if (!stall) state_next = ICU_VEC_HI;
            ICU_VEC_HI:  if (!stall) state_next = ICU_VEC_LO;
            ICU_VEC_LO:  if (!stall) state_next = ICU_LOAD;
            ICU_LOAD:    if (!stall) state_next = ICU_IDLE;
            default:     state_next = ICU_IDLE;
        endcase
    end

    always_comb begin
        branch_d     = 1'b0;
        data_read_d  = 1'b0;
        data_write_d = 1'b0;
        dmr_d        = 1'b0;
        dmw_d        = 1'b0;
        stack_op_d   = 1'b0;
        push_pop_d   = 1'b0;
        write_sp_d   = 1'b0;
        alu_d        = NOP_ALU;
        stack_wdata  = '0;
        mem_addr     = '0;
        pc_next      = '0;
        pc_write     = 1'b0;
        case (state)
            ICU_PUSH_HI, ICU_PUSH_LO: begin
                stack_wdata = (state == ICU_PUSH_HI) ? pc_saved[PC_WIDTH-1 -: DATA_WIDTH]
                                                     : pc_saved[DATA_WIDTH-1:0];
                dmw_d       = 1'b1;
                stack_op_d  = 1'b1;
                push_pop_d  = 1'b1;
                write_sp_d  = 1'b1;
                alu_d       = PUSH_ALU;
            end
            ICU_VEC_HI: begin
                dmr_d    = 1'b1;
                mem_addr = VECTOR_ADDR;
            end
            ICU_VEC_LO: begin
                dmr_d    = 1'b1;
                mem_addr = VECTOR_ADDR + PC_WIDTH'(1);
            end
            ICU_LOAD: begin
                pc_next  = {vec_hi, mem_rdata};
                branch_d = 1'b1;
                pc_write = !stall;
            end
            default: ;
        endcase
    end

    assign int_flag      = (state != ICU_IDLE);
    assign fetch_hold    = (state != ICU_IDLE);
    assign flags_restore = restore_q && !stall;

    // The CU drives these nets whenever the ICU is idle, so release them.
    assign branch          = int_flag ? branch_d     : 1'bz;
    assign data_read       = int_flag ? data_read_d  : 1'bz;
    assign data_write      = int_flag ? data_write_d : 1'bz;
    assign DMR             = int_flag ? dmr_d        : 1'bz;
    assign DMW             = int_flag ? dmw_d        : 1'bz;
    assign stack_operation = int_flag ? stack_op_d   : 1'bz;
    assign push_pop        = int_flag ? push_pop_d   : 1'bz;
    assign write_sp        = int_flag ? write_sp_d   : 1'bz;
    assign alu_function    = int_flag ? alu_d        : 4'bzzzz;

endmodule

// File: tb/tb_interrupt_control_unit.sv
// Self-checking bench for interrupt_control_unit: table of interrupt entries
// plus hand sequences, with an event scoreboard for pushes, PC loads and restores.
module tb_interrupt_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        int_req;
    logic        stall;
    logic [31:0] pc;
    logic [2:0]  flags;
    logic        rti;
    logic [15:0] mem_rdata = 16'h0000;
    logic        int_flag, fetch_hold, pc_write, flags_restore;
    logic [15:0] stack_wdata;
    logic [31:0] mem_addr, pc_next;
    logic [2:0]  saved_flags;
    wire         branch, data_read, data_write, DMR, DMW;
    wire         stack_operation, push_pop, write_sp;
    wire  [3:0]  alu_function;

    logic [15:0] vec_hi_word, vec_lo_word;

    interrupt_control_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .int_req         (int_req),
        .stall           (stall),
        .pc              (pc),
        .flags           (flags),
        .rti             (rti),
        .mem_rdata       (mem_rdata),
        .int_flag        (int_flag),
        .fetch_hold      (fetch_hold),
        .branch          (branch),
        .data_read       (data_read),
        .data_write      (data_write),
        .DMR             (DMR),
        .DMW             (DMW),
        .stack_operation (stack_operation),
        .push_pop        (push_pop),
        .write_sp        (write_sp),
        .alu_function    (alu_function),
        .stack_wdata     (stack_wdata),
        .mem_addr        (mem_addr),
        .pc_write        (pc_write),
        .pc_next         (pc_next),
        .saved_flags     (saved_flags),
        .flags_restore   (flags_restore)
    );

    always #5 clk = ~clk;

    wire bus_z = (branch === 1'bz) && (data_read === 1'bz) && (data_write === 1'bz) &&
                 (DMR === 1'bz) && (DMW === 1'bz) && (stack_operation === 1'bz) &&
                 (push_pop === 1'bz) && (write_sp === 1'bz) && (alu_function === 4'bzzzz);
    wire bus_zero = (branch === 1'b0) && (data_read === 1'b0) && (data_write === 1'b0) &&
                    (DMR === 1'b0) && (DMW === 1'b0) && (stack_operation === 1'b0) &&
                    (push_pop === 1'b0) && (write_sp === 1'b0) && (alu_function === 4'b0000);

    // Synchronous data memory: vector words live at 2 and 3.
    always @(posedge clk) begin
        if (int_flag && DMR) begin
            mem_rdata <= (mem_addr == 32'h2) ? vec_hi_word :
                         (mem_addr == 32'h3) ? vec_lo_word : 16'hDEAD;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef enum logic [1:0] {EV_PUSH, EV_PCW, EV_FR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];

    task automatic observe(input ev_kind_t kind, input logic [31:0] data, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: unexpected event data %h, none expected", name, data);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, 32'(kind), 32'(e.kind));
            check({name, "_data"}, data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (int_flag && !stall && DMW && stack_operation && push_pop)
                observe(EV_PUSH, {16'h0, stack_wdata}, "push");
            if (pc_write) begin
                observe(EV_PCW, pc_next, "pc_write");
                check("pcw_branch", {31'b0, branch}, 32'h1);
            end
            if (flags_restore)
                observe(EV_FR, {29'b0, saved_flags}, "restore");
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  flags;
        logic [15:0] vh, vl;
        logic [31:0] stall_mask, irq_mask, rti_mask;
        logic [15:0] exp_hi, exp_lo;
        logic [31:0] exp_next;
        int          exp_len;
        int          services;
    } vec_t;
    vec_t vecs[6];

    task automatic applyStimulus;
        int n;
        @(posedge clk); #1 int_req = 1'b1;
        @(posedge clk); #1 int_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!int_flag && n < 10);
        check("entry_latency", 32'(n), 32'd2);
    endtask

    // Starts at a negedge inside an int_flag window; bit k of each mask drives cycle k.
    task automatic measure_window(input logic [31:0] sm, input logic [31:0] im,
                                  input logic [31:0] rm, output int len, output int holds);
        len = 0;
        holds = 0;
        while (int_flag && len < 20) begin
            if (fetch_hold) holds++;
            len++;
            @(posedge clk); #1;
            stall   = sm[len];
            int_req = im[len];
            rti     = rm[len];
            @(negedge clk);
        end
        stall = 1'b0; int_req = 1'b0; rti = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_int_flag"},      32'(int_flag),      32'h0);
        check({tag, "_fetch_hold"},    32'(fetch_hold),    32'h0);
        check({tag, "_pc_write"},      32'(pc_write),      32'h0);
        check({tag, "_flags_restore"}, 32'(flags_restore), 32'h0);
        check({tag, "_stack_wdata"},   32'(stack_wdata),   32'h0);
        check({tag, "_mem_addr"},      mem_addr,           32'h0);
        check({tag, "_pc_next"},       pc_next,            32'h0);
        check({tag, "_saved_flags"},   32'(saved_flags),   32'h0);
        check({tag, "_bus_z"},         32'(bus_z),         32'h1);
    endtask

    task automatic run_entry(input vec_t v);
        int len, holds, quiet;
        pc = v.pc; flags = v.flags; vec_hi_word = v.vh; vec_lo_word = v.vl;
        for (int s = 0; s < v.services; s++) begin
            exp_q.push_back('{EV_PUSH, {16'h0, v.exp_hi}});
            exp_q.push_back('{EV_PUSH, {16'h0, v.exp_lo}});
            exp_q.push_back('{EV_PCW, v.exp_next});
        end
        @(negedge clk);
        check("idle_bus_z", 32'(bus_z), 32'h1);
        applyStimulus();
        check("drain_bus_zero", 32'(bus_zero), 32'h1);
        measure_window(v.stall_mask, v.irq_mask, v.rti_mask, len, holds);
        check("int_flag_len", 32'(len), 32'(v.exp_len));
        check("fetch_hold_len", 32'(holds), 32'(v.exp_len));
        check("saved_flags", 32'(saved_flags), 32'(v.flags));
        if (v.services == 2) begin
            @(negedge clk);
            check("b2b_restart", 32'(int_flag), 32'h1);
            measure_window(32'h0, 32'h0, 32'h0, len, holds);
            check("b2b_len", 32'(len), 32'd8);
        end
        quiet = 1;
        repeat (6) begin
            @(negedge clk);
            if (int_flag) quiet = 0;
        end
        check("no_extra_service", 32'(quiet), 32'h1);
        exp_q.push_back('{EV_FR, {29'b0, v.flags}});
        @(posedge clk); #1 rti = 1'b1;
        @(posedge clk); #1 rti = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic reset_mid_sequence;
        int seen;
        pc = 32'hCAFE_0123; flags = 3'b011;
        exp_q.push_back('{EV_PUSH, 32'h0000_CAFE});
        applyStimulus();
        repeat (3) @(negedge clk);
        check("pre_reset_push_hi", 32'(stack_wdata), 32'h0000_CAFE);
        #1 rst_n = 1'b0;
        #1 checkOutput("mid_reset");
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (int_flag || pc_write) seen++;
        end
        check("post_reset_quiet", 32'(seen), 32'h0);
    endtask

    initial begin
        vecs[0] = '{32'h0001_2345, 3'b101, 16'h0000, 16'h0200, 32'h00, 32'h00, 32'h00,
                    16'h0001, 16'h2345, 32'h0000_0200, 8, 1};
        vecs[1] = '{32'h1234_5678, 3'b010, 16'h00AB, 16'hCDEF, 32'h30, 32'h00, 32'h00,
                    16'h1234, 16'h5678, 32'h00AB_CDEF, 10, 1};
        vecs[2] = '{32'hFFFF_0000, 3'b111, 16'hFFFF, 16'hFFFE, 32'h80, 32'h00, 32'h00,
                    16'hFFFF, 16'h0000, 32'hFFFF_FFFE, 9, 1};
        vecs[3] = '{32'h8000_0001, 3'b001, 16'h1000, 16'h0004, 32'h00, 32'h20, 32'h00,
                    16'h8000, 16'h0001, 32'h1000_0004, 8, 2};
        vecs[4] = '{32'h0000_FFFE, 3'b110, 16'h0001, 16'h8000, 32'h00, 32'h2A, 32'h00,
                    16'h0000, 16'hFFFE, 32'h0001_8000, 8, 2};
        vecs[5] = '{32'h4321_8765, 3'b100, 16'h0ACE, 16'hBEEF, 32'h02, 32'h00, 32'h1C,
                    16'h4321, 16'h8765, 32'h0ACE_BEEF, 9, 1};

        rst_n = 1'b0; int_req = 1'b0; stall = 1'b0; rti = 1'b0;
        pc = '0; flags = '0; vec_hi_word = '0; vec_lo_word = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset");
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_entry(vecs[i]);
        reset_mid_sequence();

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
